// File: rtl/akkanat_dmem_responder_if.sv
// Bus between the akkanat core/test host and the memory responder: fetch port,
// data port, write-log drain port and the sticky error flag.
interface akkanat_dmem_responder_if;
    logic [31:0] pc_i;
    logic [31:0] inst_o;
    logic [31:0] data_mem_addr_i;
    logic [31:0] data_mem_wdata_i;
    logic        data_mem_we_i;
    logic [31:0] data_mem_rdata_o;
    logic        log_valid_o;
    logic        log_ready_i;
    logic [63:0] log_data_o;
    logic        err_o;

    modport master (
        output pc_i,
        output data_mem_addr_i,
        output data_mem_wdata_i,
        output data_mem_we_i,
        output log_ready_i,
        input  inst_o,
        input  data_mem_rdata_o,
        input  log_valid_o,
        input  log_data_o,
        input  err_o
    );

    modport slave (
        input  pc_i,
        input  data_mem_addr_i,
        input  data_mem_wdata_i,
        input  data_mem_we_i,
        input  log_ready_i,
        output inst_o,
        output data_mem_rdata_o,
        output log_valid_o,
        output log_data_o,
        output err_o
    );
endinterface

// File: rtl/akkanat_dmem_responder.sv
// Unified word RAM serving akkanat fetch and data ports, with a small MMIO window
// (cycle counter, write-log status/control, scratch) and a write-log FIFO.
module akkanat_dmem_responder #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter string       INIT_FILE = "",
    parameter int unsigned LOG_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input logic clk_i,
    input logic rst_i,
    akkanat_dmem_responder_if.slave bus
);
    localparam int unsigned AW  = $clog2(MEM_WORDS);
    localparam int unsigned LW  = $clog2(LOG_DEPTH);
    localparam int unsigned CW  = LW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        REG_CYCLE   = 2'd0,
        REG_STATUS  = 2'd1,
        REG_CTRL    = 2'd2,
        REG_SCRATCH = 2'd3
    } mmio_reg_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } log_entry_t;

    logic [31:0] mem [MEM_WORDS];
    log_entry_t  log_mem [LOG_DEPTH];

    logic [LW-1:0] wr_ptr;
    logic [LW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          err;
    logic [31:0]   cycle;
    logic [31:0]   scratch;
    logic          prev_we;
    logic [31:0]   prev_addr;
    logic [31:0]   prev_wdata;

    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          we;
    logic [31:0]   mmio_off;
    mmio_reg_e     sel;
    logic          d_in_ram;
    logic          d_in_mmio;
    logic          pc_in_ram;
    logic [AW-1:0] d_idx;
    logic [AW-1:0] pc_idx;
    logic [31:0]   status;
    logic [31:0]   rdata;

    logic ram_we;
    logic mmio_we;
    logic oor_we;
    logic misaligned;
    logic log_clear;
    logic repeat_wr;
    logic log_push;
    logic log_full;
    logic log_valid;
    logic log_pop;
    logic push_ok;
    logic unused_pc_lsb;

    assign addr  = bus.data_mem_addr_i;
    assign wdata = bus.data_mem_wdata_i;
    assign we    = bus.data_mem_we_i;

    // Address classes; RAM takes precedence should the MMIO window ever overlap it.
    assign d_in_ram  = (addr >> (AW + 2)) == 32'd0;
    assign pc_in_ram = (bus.pc_i >> (AW + 2)) == 32'd0;
    assign mmio_off  = addr - MMIO_BASE;
    assign d_in_mmio = !d_in_ram && (mmio_off < 32'd16);
    assign sel       = mmio_reg_e'(mmio_off[3:2]);
    assign d_idx     = addr[AW+1:2];
    assign pc_idx    = bus.pc_i[AW+1:2];

    assign unused_pc_lsb = ^bus.pc_i[1:0];

    assign ram_we     = we && d_in_ram;
    assign mmio_we    = we && d_in_mmio;
    assign oor_we     = we && !d_in_ram && !d_in_mmio;
    assign misaligned = ram_we && (addr[1:0] != 2'b00);
    assign log_clear  = mmio_we && (sel == REG_CTRL) && wdata[0];

    // The core holds a store for two cycles; only the first cycle is logged.
    assign repeat_wr = prev_we && (prev_addr == addr) && (prev_wdata == wdata);
    assign log_push  = ram_we && !repeat_wr;
    assign log_full  = count == CW'(LOG_DEPTH);
    assign log_valid = count != '0;
    assign log_pop   = log_valid && bus.log_ready_i;
    assign push_ok   = log_push && (!log_full || log_pop);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        status      = '0;
        status[7:0] = 8'(count);
        status[8]   = log_full;
        status[9]   = overflow;
    end

    always_comb begin
        rdata = '0;
        if (d_in_ram) begin
            rdata = mem[d_idx];
        end else if (d_in_mmio) begin
            case (sel)
                REG_CYCLE:   rdata = cycle;
                REG_STATUS:  rdata = status;
                REG_SCRATCH: rdata = scratch;
                default:     rdata = '0;
            endcase
        end
    end

    assign bus.data_mem_rdata_o = rdata;
    assign bus.inst_o           = pc_in_ram ? mem[pc_idx] : NOP;
    assign bus.log_valid_o      = log_valid;
    assign bus.log_data_o       = log_valid ? log_mem[rd_ptr] : '0;
    assign bus.err_o            = err;

    // NOTE: RAM and log storage are never reset; only the control state that gives them meaning is.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
        if (ram_we) begin
            mem[d_idx] <= wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            log_mem[wr_ptr] <= '{addr: addr, data: wdata};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle      <= '0;
            scratch    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            err        <= 1'b0;
            prev_we    <= 1'b0;
            prev_addr  <= '0;
            prev_wdata <= '0;
        end else begin
            cycle      <= cycle + 32'd1;
            prev_we    <= we;
            prev_addr  <= addr;
            prev_wdata <= wdata;

            if (mmio_we && (sel == REG_SCRATCH)) begin
                scratch <= wdata;
            end
            if (oor_we || misaligned) begin
                err <= 1'b1;
            end

            // A clear overrides a same-cycle pop; it can never meet a push.
            if (log_clear) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (log_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (log_push && log_full && !log_pop) begin
                    overflow <= 1'b1;
                end
                case ({push_ok, log_pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_akkanat_dmem_responder.sv
// Scoreboard bench for akkanat_dmem_responder: expected log entries are queued when
// a loggable write is driven and compared as the host drains the FIFO.
module tb_akkanat_dmem_responder;
    localparam int unsigned MEM_WORDS = 1024;
    localparam int unsigned LOG_DEPTH = 8;
    localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;
    localparam logic [31:0] A_CYCLE   = MMIO_BASE;
    localparam logic [31:0] A_STATUS  = MMIO_BASE + 32'h4;
    localparam logic [31:0] A_CTRL    = MMIO_BASE + 32'h8;
    localparam logic [31:0] A_SCRATCH = MMIO_BASE + 32'hC;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [63:0] sb [$];

    akkanat_dmem_responder_if bus ();

    akkanat_dmem_responder #(
        .MEM_WORDS(MEM_WORDS),
        .INIT_FILE(""),
        .LOG_DEPTH(LOG_DEPTH),
        .MMIO_BASE(MMIO_BASE)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.data_mem_we_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input int hold);
        bus.data_mem_addr_i  = a;
        bus.data_mem_wdata_i = d;
        bus.data_mem_we_i    = 1'b1;
        repeat (hold) tick();
        bus.data_mem_we_i    = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        bus.data_mem_addr_i = a;
        bus.data_mem_we_i   = 1'b0;
        #1;
        v = bus.data_mem_rdata_o;
    endtask

    task automatic drain(input string name);
        int budget;
        logic [63:0] exp;
        budget = 4 * LOG_DEPTH;
        bus.log_ready_i = 1'b1;
        #1;
        while (bus.log_valid_o === 1'b1 && budget > 0) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL %s extra entry: got %h, none expected", name, bus.log_data_o);
            end else begin
                exp = sb.pop_front();
                if (bus.log_data_o !== exp) begin
                    n_bad++;
                    $display("FAIL %s entry: got %h expected %h", name, bus.log_data_o, exp);
                end
            end
            tick();
            budget--;
        end
        bus.log_ready_i = 1'b0;
        n_cmp++;
        if (bus.log_valid_o !== 1'b0 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s end: valid=%b missing=%0d expected valid=0 missing=0",
                     name, bus.log_valid_o, sb.size());
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        n_cmp++;
        if (bus.log_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", bus.log_valid_o); end
        n_cmp++;
        if (bus.log_data_o !== 64'h0) begin n_bad++; $display("FAIL reset_data: got %h expected 0", bus.log_data_o); end
        n_cmp++;
        if (bus.err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", bus.err_o); end
        rd(A_STATUS, v);
        n_cmp++;
        if (v !== 32'h0) begin n_bad++; $display("FAIL reset_status: got %h expected 0", v); end
        rd(A_SCRATCH, v);
        n_cmp++;
        if (v !== 32'h0) begin n_bad++; $display("FAIL reset_scratch: got %h expected 0", v); end
    endtask

    task automatic test_cycle();
        logic [31:0] v;
        do_reset();
        rd(A_CYCLE, v);
        n_cmp++;
        if (v !== 32'd0) begin n_bad++; $display("FAIL cycle_0: got %0d expected 0", v); end
        repeat (10) tick();
        rd(A_CYCLE, v);
        n_cmp++;
        if (v !== 32'd10) begin n_bad++; $display("FAIL cycle_10: got %0d expected 10", v); end
    endtask

    task automatic test_read_path();
        logic [31:0] v;
        sb.push_back({32'h14, 32'hDEAD_BEEF});
        wr(32'h14, 32'hDEAD_BEEF, 1);
        rd(32'h14, v);
        n_cmp++;
        if (v !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_word5: got %h expected deadbeef", v); end
        rd(32'h17, v);
        n_cmp++;
        if (v !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_unaligned: got %h expected deadbeef", v); end
        bus.pc_i = 32'h14;
        #1;
        n_cmp++;
        if (bus.inst_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL inst_word5: got %h expected deadbeef", bus.inst_o); end
        bus.pc_i = 32'h0001_0000;
        #1;
        n_cmp++;
        if (bus.inst_o !== 32'h13) begin n_bad++; $display("FAIL inst_oor_nop: got %h expected 13", bus.inst_o); end
        n_cmp++;
        if (bus.err_o !== 1'b0) begin n_bad++; $display("FAIL inst_oor_err: got %b expected 0", bus.err_o); end
        drain("rd_log");

        // Read-during-write returns the old word until the edge has passed.
        sb.push_back({32'h14, 32'h1111_1111});
        bus.data_mem_addr_i  = 32'h14;
        bus.data_mem_wdata_i = 32'h1111_1111;
        bus.data_mem_we_i    = 1'b1;
        #1;
        n_cmp++;
        if (bus.data_mem_rdata_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rdw_old: got %h expected deadbeef", bus.data_mem_rdata_o); end
        tick();
        n_cmp++;
        if (bus.data_mem_rdata_o !== 32'h1111_1111) begin n_bad++; $display("FAIL rdw_new: got %h expected 11111111", bus.data_mem_rdata_o); end
        tick();
        bus.data_mem_we_i = 1'b0;
        drain("rdw_log");
    endtask

    task automatic test_store_hold();
        logic [31:0] v;
        sb.push_back({32'h20, 32'h1234});
        wr(32'h20, 32'h1234, 2);
        rd(A_STATUS, v);
        n_cmp++;
        if (v !== 32'h001) begin n_bad++; $display("FAIL hold_status: got %h expected 001", v); end
        rd(32'h20, v);
        n_cmp++;
        if (v !== 32'h1234) begin n_bad++; $display("FAIL hold_ram: got %h expected 1234", v); end
        drain("hold_log");
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        bus.log_ready_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) sb.push_back({32'h100 + 32'(4 * i), 32'hA000 + 32'(i)});
            wr(32'h100 + 32'(4 * i), 32'hA000 + 32'(i), 1);
        end
        rd(A_STATUS, v);
        n_cmp++;
        if (v !== 32'h308) begin n_bad++; $display("FAIL ovf_status: got %h expected 308", v); end
        drain("ovf_log");
        rd(A_STATUS, v);
        n_cmp++;
        if (v !== 32'h200) begin n_bad++; $display("FAIL ovf_sticky: got %h expected 200", v); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] v;
        logic [63:0] exp;
        wr(A_CTRL, 32'h1, 1);
        rd(A_STATUS, v);
        n_cmp++;
        if (v !== 32'h0) begin n_bad++; $display("FAIL ctrl_clear_ovf: got %h expected 0", v); end
        for (int i = 0; i < 8; i++) begin
            sb.push_back({32'h200 + 32'(4 * i), 32'hB000 + 32'(i)});
            wr(32'h200 + 32'(4 * i), 32'hB000 + 32'(i), 1);
        end
        rd(A_STATUS, v);
        n_cmp++;
        if (v !== 32'h108) begin n_bad++; $display("FAIL full_status: got %h expected 108", v); end
        // Pop the head and push a new tail on the same edge.
        bus.log_ready_i      = 1'b1;
        bus.data_mem_addr_i  = 32'h240;
        bus.data_mem_wdata_i = 32'hB0FF;
        bus.data_mem_we_i    = 1'b1;
        #1;
        exp = sb.pop_front();
        n_cmp++;
        if (bus.log_data_o !== exp) begin n_bad++; $display("FAIL full_head: got %h expected %h", bus.log_data_o, exp); end
        sb.push_back({32'h240, 32'hB0FF});
        tick();
        bus.data_mem_we_i = 1'b0;
        bus.log_ready_i   = 1'b0;
        rd(A_STATUS, v);
        n_cmp++;
        if (v !== 32'h108) begin n_bad++; $display("FAIL pushpop_status: got %h expected 108", v); end
        drain("pushpop_log");
    endtask

    task automatic test_mmio();
        logic [31:0] v;
        wr(A_SCRATCH, 32'hA5, 1);
        rd(A_SCRATCH, v);
        n_cmp++;
        if (v !== 32'hA5) begin n_bad++; $display("FAIL scratch: got %h expected a5", v); end
        rd(A_CTRL, v);
        n_cmp++;
        if (v !== 32'h0) begin n_bad++; $display("FAIL ctrl_read: got %h expected 0", v); end
        wr(A_CYCLE, 32'h5555, 1);
        wr(A_STATUS, 32'h5555, 1);
        n_cmp++;
        if (bus.err_o !== 1'b0) begin n_bad++; $display("FAIL ro_write_err: got %b expected 0", bus.err_o); end
        for (int i = 0; i < 3; i++) wr(32'h300 + 32'(4 * i), 32'hC000 + 32'(i), 1);
        rd(A_STATUS, v);
        n_cmp++;
        if (v !== 32'h003) begin n_bad++; $display("FAIL clear_pre: got %h expected 003", v); end
        // Clear together with a pending pop; the clear wins.
        bus.log_ready_i = 1'b1;
        wr(A_CTRL, 32'h1, 1);
        bus.log_ready_i = 1'b0;
        n_cmp++;
        if (bus.log_valid_o !== 1'b0) begin n_bad++; $display("FAIL clear_valid: got %b expected 0", bus.log_valid_o); end
        rd(A_STATUS, v);
        n_cmp++;
        if (v !== 32'h0) begin n_bad++; $display("FAIL clear_status: got %h expected 0", v); end
    endtask

    task automatic test_error();
        logic [31:0] v;
        sb.push_back({32'h0, 32'hCAFE_0000});
        wr(32'h0, 32'hCAFE_0000, 1);
        drain("err_setup");
        bus.data_mem_addr_i  = 32'h8000_0000;
        bus.data_mem_wdata_i = 32'h77;
        bus.data_mem_we_i    = 1'b1;
        #1;
        n_cmp++;
        if (bus.err_o !== 1'b0) begin n_bad++; $display("FAIL err_early: got %b expected 0", bus.err_o); end
        tick();
        bus.data_mem_we_i = 1'b0;
        n_cmp++;
        if (bus.err_o !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b expected 1", bus.err_o); end
        rd(32'h0, v);
        n_cmp++;
        if (v !== 32'hCAFE_0000) begin n_bad++; $display("FAIL oor_ram_kept: got %h expected cafe0000", v); end
        rd(32'h8000_0000, v);
        n_cmp++;
        if (v !== 32'h0) begin n_bad++; $display("FAIL oor_read: got %h expected 0", v); end
        n_cmp++;
        if (bus.log_valid_o !== 1'b0) begin n_bad++; $display("FAIL oor_logged: got %b expected 0", bus.log_valid_o); end

        // Reset in the middle of a drain discards the log but keeps RAM.
        wr(32'h30, 32'h99, 1);
        wr(32'h34, 32'h9A, 1);
        n_cmp++;
        if (bus.log_valid_o !== 1'b1) begin n_bad++; $display("FAIL pre_reset_valid: got %b expected 1", bus.log_valid_o); end
        do_reset();
        n_cmp++;
        if (bus.err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b expected 0", bus.err_o); end
        n_cmp++;
        if (bus.log_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b expected 0", bus.log_valid_o); end
        rd(32'h0, v);
        n_cmp++;
        if (v !== 32'hCAFE_0000) begin n_bad++; $display("FAIL rst_ram0: got %h expected cafe0000", v); end
        rd(32'h20, v);
        n_cmp++;
        if (v !== 32'h1234) begin n_bad++; $display("FAIL rst_ram8: got %h expected 1234", v); end
    endtask

    task automatic test_misaligned();
        logic [31:0] v;
        sb.push_back({32'h22, 32'h5678});
        wr(32'h22, 32'h5678, 1);
        rd(32'h20, v);
        n_cmp++;
        if (v !== 32'h5678) begin n_bad++; $display("FAIL misal_ram: got %h expected 5678", v); end
        n_cmp++;
        if (bus.err_o !== 1'b1) begin n_bad++; $display("FAIL misal_err: got %b expected 1", bus.err_o); end
        drain("misal_log");
        do_reset();
        n_cmp++;
        if (bus.err_o !== 1'b0) begin n_bad++; $display("FAIL misal_rst_err: got %b expected 0", bus.err_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pc_i             = 32'h0;
        bus.data_mem_addr_i  = 32'h0;
        bus.data_mem_wdata_i = 32'h0;
        bus.data_mem_we_i    = 1'b0;
        bus.log_ready_i      = 1'b0;
        tick();
        test_reset();
        test_cycle();
        test_read_path();
        test_store_hold();
        test_overflow();
        test_full_push_pop();
        test_mmio();
        test_error();
        test_misaligned();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
